port_wr_sram_selector: RTL and testbench

PORT_WR_SRAM_SELECTOR -- requirements
Module: port_wr_sram_selector

---
 rtl/port_wr_sram_selector_if.sv | 36 +++
 rtl/port_wr_sram_selector.sv | 134 +++++++++++++
 tb/tb_port_wr_sram_selector.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/port_wr_sram_selector_if.sv
// Request/candidate/result bundle for the port write SRAM selector.
// slave: the selector; master: the requester that also feeds the candidate stream.
interface port_wr_sram_selector_if #(
  parameter int unsigned IDX_W   = 5,
  parameter int unsigned LEN_W   = 9,
  parameter int unsigned SPACE_W = 11,
  parameter int unsigned AMT_W   = 9,
  parameter int unsigned TICK_W  = 8
);
  logic [TICK_W-1:0]  match_threshold;
  logic [TICK_W-1:0]  match_timeout;
  logic               match_mode;
  logic [LEN_W-1:0]   new_length;
  logic               match_enable;
  logic               match_suc;
  logic               match_fail;
  logic [IDX_W-1:0]   matching_sram;
  logic               accessible;
  logic [SPACE_W-1:0] free_space;
  logic [AMT_W-1:0]   packet_amount;
  logic [IDX_W-1:0]   matched_sram;
  logic [SPACE_W-1:0] best_metric;
  logic               update_matched_sram;

  modport master (
    output match_threshold, match_timeout, match_mode, new_length, match_enable,
    output matching_sram, accessible, free_space, packet_amount,
    input  match_suc, match_fail, matched_sram, best_metric, update_matched_sram
  );

  modport slave (
    input  match_threshold, match_timeout, match_mode, new_length, match_enable,
    input  matching_sram, accessible, free_space, packet_amount,
    output match_suc, match_fail, matched_sram, best_metric, update_matched_sram
  );
endinterface

// File: rtl/port_wr_sram_selector.sv
// Scans a stream of SRAM candidates and keeps the best one for a pending packet write.
// Define PORT_WR_SRAM_TIMEOUT_EN to enable the match_timeout fail path.
module port_wr_sram_selector #(
  parameter int unsigned NUM_SRAM = 32,
  parameter int unsigned IDX_W    = 5,
  parameter int unsigned LEN_W    = 9,
  parameter int unsigned SPACE_W  = 11,
  parameter int unsigned AMT_W    = 9,
  parameter int unsigned TICK_W   = 8
) (
  input logic                    clk,
  input logic                    rst,
  port_wr_sram_selector_if.slave bus
);

  localparam int unsigned CmpW = (LEN_W > SPACE_W) ? LEN_W : SPACE_W;

  typedef enum logic [1:0] {StIdle, StScan, StDone, StWaitRel} state_e;

  state_e             state_q, state_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic               found_q, found_d;
  logic [SPACE_W-1:0] best_q, best_d;
  logic [IDX_W-1:0]   matched_q, matched_d;
  logic               mode_q, mode_d;
  logic [LEN_W-1:0]   len_q, len_d;

  logic [SPACE_W-1:0] metric;
  logic               space_ok;
  logic               in_range;
  logic               qualify;
  logic               timeout_hit;

  assign metric   = mode_q ? bus.free_space : SPACE_W'(bus.packet_amount);
  assign space_ok = CmpW'(bus.free_space) >= CmpW'(len_q);
  assign in_range = 32'(bus.matching_sram) < NUM_SRAM;
  // >= on the metric makes ties go to the later candidate.
  assign qualify  = (state_q == StScan) && bus.match_enable && bus.accessible &&
                    in_range && space_ok && (metric >= best_q);

`ifdef PORT_WR_SRAM_TIMEOUT_EN
  assign timeout_hit = !found_q && (tick_q == bus.match_timeout);
`else
  logic unused_timeout;
  assign unused_timeout = ^bus.match_timeout;
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      tick_q    <= '0;
      found_q   <= 1'b0;
      best_q    <= '0;
      matched_q <= '0;
      mode_q    <= 1'b0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      found_q   <= found_d;
      best_q    <= best_d;
      matched_q <= matched_d;
      mode_q    <= mode_d;
      len_q     <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (bus.match_enable) state_d = StScan;
      StScan: begin
        if (!bus.match_enable) begin
          state_d = StIdle;
        end else if (found_q && (tick_q >= bus.match_threshold)) begin
          state_d = StDone;
        end else if (timeout_hit) begin
          state_d = StDone;
        end
      end
      StDone:    state_d = StWaitRel;
      StWaitRel: if (!bus.match_enable) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    tick_d    = tick_q;
    found_d   = found_q;
    best_d    = best_q;
    matched_d = matched_q;
    mode_d    = mode_q;
    len_d     = len_q;
    if (state_q == StIdle) begin
      // matched_sram deliberately survives into the next scan until a candidate qualifies.
      tick_d  = '0;
      found_d = 1'b0;
      best_d  = '0;
      if (bus.match_enable) begin
        mode_d = bus.match_mode;
        len_d  = bus.new_length;
      end
    end else if (state_q == StScan) begin
      if (!bus.match_enable) begin
        tick_d  = '0;
        found_d = 1'b0;
        best_d  = '0;
      end else begin
        if (tick_q != '1) tick_d = tick_q + TICK_W'(1);
        if (qualify) begin
          found_d   = 1'b1;
          best_d    = metric;
          matched_d = bus.matching_sram;
        end
      end
    end
  end

  // DONE is reached with found set only on success, so found selects the pulse.
  always_comb begin
    bus.match_suc           = (state_q == StDone) && found_q;
`ifdef PORT_WR_SRAM_TIMEOUT_EN
    bus.match_fail          = (state_q == StDone) && !found_q;
`else
    bus.match_fail          = 1'b0;
`endif
    bus.update_matched_sram = qualify;
  end

  assign bus.matched_sram = matched_q;
  assign bus.best_metric  = best_q;

endmodule

// File: tb/tb_port_wr_sram_selector.sv
// Directed self-checking bench for port_wr_sram_selector.
module tb_port_wr_sram_selector;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pulses;

  always #5 clk = ~clk;

  port_wr_sram_selector_if #(
    .IDX_W(5), .LEN_W(9), .SPACE_W(11), .AMT_W(9), .TICK_W(8)
  ) bus ();

  port_wr_sram_selector #(
    .NUM_SRAM(32), .IDX_W(5), .LEN_W(9), .SPACE_W(11), .AMT_W(9), .TICK_W(8)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cand(input logic [4:0] idx, input logic acc, input logic [10:0] space,
                      input logic [8:0] amt);
    bus.matching_sram = idx;
    bus.accessible    = acc;
    bus.free_space    = space;
    bus.packet_amount = amt;
    #1;
  endtask

  task automatic start_scan(input logic mode, input logic [8:0] len, input logic [7:0] thr);
    bus.match_mode      = mode;
    bus.new_length      = len;
    bus.match_threshold = thr;
    bus.match_enable    = 1'b1;
    step();
  endtask

  task automatic release_req();
    bus.match_enable = 1'b0;
    cand(5'd0, 1'b0, 11'd0, 9'd0);
    step();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst                 = 1'b1;
    bus.match_enable    = 1'b0;
    bus.match_mode      = 1'b0;
    bus.new_length      = '0;
    bus.match_threshold = '0;
    bus.match_timeout   = 8'hFF;
    cand(5'd0, 1'b0, 11'd0, 9'd0);
    step();
    step();
    chk("rst_suc", 32'(bus.match_suc), 0);
    chk("rst_fail", 32'(bus.match_fail), 0);
    chk("rst_matched", 32'(bus.matched_sram), 0);
    chk("rst_best", 32'(bus.best_metric), 0);
    chk("rst_upd", 32'(bus.update_matched_sram), 0);
    rst = 1'b0;
    step();

    // Threshold 3, SRAM4 qualifies at tick 0: success in SCAN cycle 4.
    start_scan(1'b0, 9'd10, 8'd3);
    cand(5'd4, 1'b1, 11'd100, 9'd7);
    chk("t1_upd", 32'(bus.update_matched_sram), 1);
    step();
    cand(5'd0, 1'b0, 11'd0, 9'd0);
    chk("t1_best", 32'(bus.best_metric), 7);
    for (int c = 1; c <= 5; c++) begin
      chk("t1_suc", 32'(bus.match_suc), 32'(c == 4));
      chk("t1_fail", 32'(bus.match_fail), 0);
      if (c == 4) chk("t1_matched", 32'(bus.matched_sram), 4);
      step();
    end
    release_req();

    // Affinity mode keeps SRAM2 (amt 5 beats 2).
    start_scan(1'b0, 9'd50, 8'd0);
    cand(5'd2, 1'b1, 11'd100, 9'd5);
    chk("t2a_upd0", 32'(bus.update_matched_sram), 1);
    step();
    cand(5'd9, 1'b1, 11'd900, 9'd2);
    chk("t2a_upd1", 32'(bus.update_matched_sram), 0);
    chk("t2a_nosuc", 32'(bus.match_suc), 0);
    step();
    chk("t2a_suc", 32'(bus.match_suc), 1);
    chk("t2a_matched", 32'(bus.matched_sram), 2);
    chk("t2a_best", 32'(bus.best_metric), 5);
    release_req();

    // Balance mode moves to SRAM9 (space 900 beats 100); old match held until then.
    start_scan(1'b1, 9'd50, 8'd0);
    chk("t2b_hold", 32'(bus.matched_sram), 2);
    chk("t2b_clr", 32'(bus.best_metric), 0);
    cand(5'd2, 1'b1, 11'd100, 9'd5);
    chk("t2b_upd0", 32'(bus.update_matched_sram), 1);
    step();
    cand(5'd9, 1'b1, 11'd900, 9'd2);
    chk("t2b_upd1", 32'(bus.update_matched_sram), 1);
    step();
    chk("t2b_suc", 32'(bus.match_suc), 1);
    chk("t2b_matched", 32'(bus.matched_sram), 9);
    chk("t2b_best", 32'(bus.best_metric), 900);
    release_req();

    // Space check, tie to later candidate, inaccessible rejected; threshold 5.
    start_scan(1'b0, 9'd300, 8'd5);
    cand(5'd1, 1'b1, 11'd299, 9'd9);
    chk("t3_space", 32'(bus.update_matched_sram), 0);
    step();
    cand(5'd3, 1'b1, 11'd400, 9'd4);
    chk("t3_upd3", 32'(bus.update_matched_sram), 1);
    step();
    cand(5'd6, 1'b1, 11'd300, 9'd4);
    chk("t3_upd6", 32'(bus.update_matched_sram), 1);
    step();
    cand(5'd7, 1'b0, 11'd1000, 9'd9);
    chk("t3_inacc", 32'(bus.update_matched_sram), 0);
    for (int c = 3; c <= 6; c++) begin
      chk("t3_suc", 32'(bus.match_suc), 32'(c == 6));
      if (c == 6) begin
        chk("t3_matched", 32'(bus.matched_sram), 6);
        chk("t3_best", 32'(bus.best_metric), 4);
      end
      step();
    end
    release_req();

    // Timeout 10 with no accessible SRAM.
    bus.match_timeout = 8'd10;
`ifdef PORT_WR_SRAM_TIMEOUT_EN
    start_scan(1'b0, 9'd10, 8'd0);
    for (int c = 0; c <= 12; c++) begin
      chk("t4_fail", 32'(bus.match_fail), 32'(c == 11));
      chk("t4_suc", 32'(bus.match_suc), 0);
      step();
    end
`else
    start_scan(1'b0, 9'd10, 8'd0);
    pulses = 0;
    for (int c = 0; c < 300; c++) begin
      if (bus.match_suc || bus.match_fail) pulses++;
      step();
    end
    chk("t4_nopulse", 32'(pulses), 0);
`endif
    release_req();
    bus.match_timeout = 8'hFF;

    // Abort by dropping enable at tick 2.
    start_scan(1'b0, 9'd10, 8'd0);
    step();
    step();
    bus.match_enable = 1'b0;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus.match_suc || bus.match_fail) pulses++;
    end
    chk("t5_abort_pulse", 32'(pulses), 0);
    chk("t5_abort_best", 32'(bus.best_metric), 0);

    // Reset pulsed mid-scan after a qualify.
    bus.match_enable = 1'b1;
    step();
    cand(5'd5, 1'b1, 11'd100, 9'd3);
    chk("t5_upd", 32'(bus.update_matched_sram), 1);
    step();
    chk("t5_pre_rst", 32'(bus.matched_sram), 5);
    rst = 1'b1;
    #1;
    chk("t5_rst_matched", 32'(bus.matched_sram), 0);
    chk("t5_rst_best", 32'(bus.best_metric), 0);
    chk("t5_rst_suc", 32'(bus.match_suc), 0);
    chk("t5_rst_fail", 32'(bus.match_fail), 0);
    chk("t5_rst_upd", 32'(bus.update_matched_sram), 0);
    step();
    rst = 1'b0;
    cand(5'd8, 1'b1, 11'd100, 9'd1);
    step();
    chk("t5_restart", 32'(bus.update_matched_sram), 1);
    step();
    cand(5'd0, 1'b0, 11'd0, 9'd0);
    step();
    chk("t5_suc", 32'(bus.match_suc), 1);
    chk("t5_matched", 32'(bus.matched_sram), 8);

    // Enable held high after DONE: no re-match until it toggles.
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (bus.match_suc || bus.match_fail) pulses++;
    end
    chk("t6_held", 32'(pulses), 0);
    bus.match_enable = 1'b0;
    step();
    bus.match_enable = 1'b1;
    step();
    cand(5'd11, 1'b1, 11'd100, 9'd2);
    step();
    cand(5'd0, 1'b0, 11'd0, 9'd0);
    step();
    chk("t6_suc", 32'(bus.match_suc), 1);
    chk("t6_matched", 32'(bus.matched_sram), 11);
    release_req();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
